// File: rtl/rgb_seq_ctrl_if.sv
// rgb_seq_ctrl_if: valid/ready write port used to load the rgb_seq_ctrl step table.
interface rgb_seq_ctrl_if #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 12
);
    logic                     wr_valid;
    logic                     wr_ready;
    logic [$clog2(DEPTH)-1:0] wr_addr;
    logic [2:0]               wr_color;
    logic [DWELL_W-1:0]       wr_dwell;
    modport master (output wr_valid, wr_addr, wr_color, wr_dwell, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_color, wr_dwell, output wr_ready);
endinterface

// File: rtl/rgb_seq_ctrl.sv
// rgb_seq_ctrl: table-driven RGB LED step sequencer (one-shot or looping).
// Optional per-channel PWM brightness when RGB_PWM_EN is defined.
module rgb_seq_ctrl #(
    parameter int TICK_DIV = 12000,
    parameter int DEPTH    = 8,
    parameter int DWELL_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    rgb_seq_ctrl_if.slave            wr,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     loop_en,
    input  logic                     start,
    input  logic                     stop,
`ifdef RGB_PWM_EN
    input  logic [3:0]               bright,
`endif
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     done,
    output logic                     RGB_R,
    output logic                     RGB_G,
    output logic                     RGB_B
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(TICK_DIV);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [AW:0] len_q, len_d;
    logic loop_q, loop_d, done_q, done_d, tick, last;
    logic [2:0] rgb_q, rgb_d, color;
    logic [2:0] col_q [DEPTH];
    logic [2:0] col_d [DEPTH];
    logic [DWELL_W-1:0] dw_q [DEPTH];
    logic [DWELL_W-1:0] dw_d [DEPTH];
`ifdef RGB_PWM_EN
    logic [3:0] pwm_q;
`endif

    function automatic logic [DWELL_W-1:0] ticks(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    assign tick = pre_q == PW'(TICK_DIV - 1);
    assign last = {1'b0, idx_q} == len_q - 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        col_d   = col_q;
        dw_d    = dw_q;
        if (state_q == IDLE) begin
            if (wr.wr_valid) begin
                col_d[wr.wr_addr] = wr.wr_color;
                dw_d[wr.wr_addr]  = wr.wr_dwell;
            end
            // start reads col_q/dw_q, so a same-cycle write is not yet visible
            if (start && !stop && len != '0) begin
                state_d = RUN;
                len_d   = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
                loop_d  = loop_en;
                idx_d   = '0;
                pre_d   = '0;
                cnt_d   = ticks(dw_q[0]);
            end
        end else if (stop) begin
            state_d = IDLE;
            idx_d   = '0;
            pre_d   = '0;
            cnt_d   = '0;
        end else begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                if (cnt_q > DWELL_W'(1)) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!last) begin
                    idx_d = idx_q + 1'b1;
                    cnt_d = ticks(dw_q[idx_q + 1'b1]);
                end else if (loop_q) begin
                    idx_d = '0;
                    cnt_d = ticks(dw_q[0]);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
        end
        color = (state_d == RUN) ? col_q[idx_d] : 3'b000;
`ifdef RGB_PWM_EN
        rgb_d = color & {3{pwm_q < bright}};
`else
        rgb_d = color;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
            rgb_q   <= 3'b000;
            col_q   <= '{default: '0};
            dw_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
            rgb_q   <= rgb_d;
            col_q   <= col_d;
            dw_q    <= dw_d;
        end
    end

`ifdef RGB_PWM_EN
    always_ff @(posedge clk) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_q + 1'b1;
    end
`endif

    assign wr.wr_ready = state_q == IDLE;
    assign busy        = state_q == RUN;
    assign step_idx    = idx_q;
    assign done        = done_q;
    assign {RGB_R, RGB_G, RGB_B} = rgb_q;
endmodule

// File: doc/rgb_seq_ctrl.md
# rgb_seq_ctrl

Programmable sequencer for the board's RGB status LED. It holds a small table of steps, each a 3-bit colour and a dwell time in ticks. On command it plays the steps in order, either once or looping. It replaces hard-coded blink cycles: firmware-side or top-level logic loads the table through a valid/ready write port and issues start/stop, and this block drives RGB_R/RGB_G/RGB_B.

## Interface
Parameters:
- TICK_DIV, 12000: clk cycles per tick (1 ms at 12 MHz); legal values ≥ 2.
- DEPTH, 8: number of table steps; power of two, ≥ 2.
- DWELL_W, 12: dwell field width, in ticks.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  table write request.
- wr_ready  out  1  table write accepted when `wr_valid && wr_ready`.
- wr_addr  in  $clog2(DEPTH)  step index to write.
- wr_color  in  3  {R,G,B} colour for the step.
- wr_dwell  in  DWELL_W  step duration in ticks; 0 is treated as 1.
- len  in  $clog2(DEPTH)+1  number of steps to play; sampled at start.
- loop_en  in  1  1 = wrap to step 0 after the last step; sampled at start.
- start  in  1  single-cycle start command.
- stop  in  1  single-cycle abort command.
- bright  in  4  PWM duty in sixteenths; present only with RGB_PWM_EN.
- busy  out  1  high while in RUN.
- step_idx  out  $clog2(DEPTH)  current step index.
- done  out  1  one-cycle pulse at natural end of a non-looping sequence.
- RGB_R, RGB_G, RGB_B  out  1 each  LED drives, active-high, registered.

## Operation
- States: IDLE, RUN.
- Reset values:
  - state = IDLE.
  - All table entries = colour 0, dwell 0.
  - busy = 0, step_idx = 0, done = 0, RGB_* = 0.
  - wr_ready = 1.
  - Prescaler and dwell counter = 0.
- wr_ready = (state == IDLE).
  - A write is accepted only in IDLE.
  - An accepted write updates the entry on the next clock.
  - A write and a start in the same IDLE cycle: the write lands first; the start uses the table as written before that cycle.
- IDLE → RUN on `start && !stop && len != 0`.
  - Latch len, clamped to DEPTH.
  - Latch loop_en.
  - step_idx = 0; load the dwell counter from entry 0; clear the prescaler.
- start with len = 0: ignored, no done pulse.
- In RUN:
  - The prescaler counts 0..TICK_DIV-1, then wraps; each wrap is a tick.
  - Each tick decrements the dwell counter.
  - When the dwell counter expires, advance to step_idx+1 and reload the dwell counter from that entry.
- Last step (step_idx = latched_len-1) expires:
  - loop_en latched: wrap to step 0 and stay in RUN.
  - Otherwise: assert done for one cycle, RGB_* = 0, go to IDLE.
- stop in RUN:
  - Next cycle: IDLE, RGB_* = 0, step_idx = 0, no done pulse.
  - stop has priority over a simultaneous step expiry or end of sequence.
- start while in RUN: ignored; no restart.
- stop in IDLE: no effect. start and stop together in IDLE: stay in IDLE.
- rst mid-run: everything returns to reset values on the next edge, including the table.

## Timing
- All outputs are registered.
- RGB_* shows entry 0's colour on the first cycle that busy = 1, i.e. one clock after the start edge.
- Each step is displayed for exactly max(dwell,1) × TICK_DIV clocks. Colour changes are seamless: no blank cycle between steps.
- done is high during the first IDLE cycle, which is when busy falls and RGB_* go to 0.
- Total one-shot duration from the first busy cycle to the done cycle = Σ max(dwell_i,1) × TICK_DIV.
- Counter widths: prescaler $clog2(TICK_DIV); dwell counter DWELL_W. No overflow is possible.

## Configuration
- RGB_PWM_EN defined:
  - The bright port exists.
  - A free-running 4-bit pwm counter counts 0..15 on every clk, reset to 0.
  - Each RGB_* = colour bit && (pwm_cnt < bright), registered.
  - bright = 0 keeps the LED dark; bright = 15 gives 15/16 duty.
- RGB_PWM_EN undefined:
  - No bright port and no PWM counter.
  - RGB_* = colour bit directly.

## Test plan
Use TICK_DIV = 4, DEPTH = 8 for simulation.
- Reset, then write steps {0: colour 100, dwell 2; 1: colour 010, dwell 1}, len = 2, loop_en = 0, start → RGB = 100 for 8 clocks, then 010 for 4 clocks, then done pulses once, busy = 0, RGB = 000.
- Same table with loop_en = 1 → pattern 100×8, 010×4 repeats for 3 full periods with no done pulse; stop mid-step-1 → next cycle RGB = 000, busy = 0, done = 0.
- Entry with dwell 0, len = 1 → colour held for exactly 4 clocks, then done.
- Boundaries:
  - wr_valid during RUN → wr_ready = 0 and the table is unchanged.
  - start with len = 0 → no busy, no done.
  - len = 15 → clamped to 8 steps.
  - start and stop in the same cycle → stays in IDLE.
- rst asserted mid-run → next cycle all outputs at reset values; a following start with an unwritten table shows colour 000 for 4 clocks per step.
- With RGB_PWM_EN, colour 111, bright = 4 → each RGB_* high exactly 4 of every 16 clocks; bright = 0 → constantly 0.
